// File: rtl/vga_timing_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : vga_timing_pkg
//  Brief    : 640x480@60 raster timing constants shared by sync and pixel stages
//  Revision : 1.0  initial release
// ============================================================================
package vga_timing_pkg;

  localparam int COORD_W = 10;
  typedef logic [COORD_W-1:0] coord_t;

  localparam int CLK_DIV = 4;

  localparam int H_DISP  = 640;
  localparam int H_FP    = 16;
  localparam int H_SYNC  = 96;
  localparam int H_BP    = 48;
  localparam int H_TOTAL = H_DISP + H_FP + H_SYNC + H_BP;

  localparam int V_DISP  = 480;
  localparam int V_FP    = 10;
  localparam int V_SYNC  = 2;
  localparam int V_BP    = 33;
  localparam int V_TOTAL = V_DISP + V_FP + V_SYNC + V_BP;

  localparam int H_SYNC_START = H_DISP + H_FP;
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC - 1;
  localparam int V_SYNC_START = V_DISP + V_FP;
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC - 1;

  localparam logic SYNC_POL = 1'b0;

  function automatic logic in_window(input coord_t v, input coord_t lo, input coord_t hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage
`default_nettype wire

// File: rtl/vga_sync_if.sv
`default_nettype none
// ============================================================================
//  Module   : vga_sync_if
//  Brief    : raster timing bundle from vga_sync to the pixel stage / pins
//  Revision : 1.0  initial release
// ============================================================================
interface vga_sync_if;
  import vga_timing_pkg::*;

  logic   p_tick;
  coord_t xpos;
  coord_t ypos;
  logic   video_on;
  logic   hsync;
  logic   vsync;
  logic   frame_tick;

  modport master (
    output p_tick, xpos, ypos, video_on, hsync, vsync, frame_tick
  );

  modport slave (
    input  p_tick, xpos, ypos, video_on, hsync, vsync, frame_tick
  );

endinterface
`default_nettype wire

// File: rtl/vga_sync_pixel_tick_div.sv
`default_nettype none
// ============================================================================
//  Module   : pixel_tick_div
//  Brief    : one-clock pixel enable every CLK_DIV system clocks
//  Revision : 1.0  initial release
// ============================================================================
module pixel_tick_div #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  output logic p_tick
);

  if (CLK_DIV < 1) begin : g_bad_div
    $error("pixel_tick_div: CLK_DIV must be >= 1");
  end

  if (CLK_DIV == 1) begin : g_div1
    assign p_tick = ~reset;
  end else begin : g_divn
    localparam int CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end

    // Gated by reset so no enable leaks out while the raster is being cleared.
    assign p_tick = ~reset & (cnt_q == LAST);
  end

endmodule
`default_nettype wire

// File: rtl/vga_sync.sv
`default_nettype none
// ============================================================================
//  Module   : vga_sync
//  Brief    : VGA raster generator: pixel enable, H/V counters, syncs, video_on
//  Revision : 1.0  initial release
// ============================================================================
module vga_sync #(
  parameter int   CLK_DIV  = vga_timing_pkg::CLK_DIV,
  parameter int   H_DISP   = vga_timing_pkg::H_DISP,
  parameter int   H_FP     = vga_timing_pkg::H_FP,
  parameter int   H_SYNC   = vga_timing_pkg::H_SYNC,
  parameter int   H_BP     = vga_timing_pkg::H_BP,
  parameter int   V_DISP   = vga_timing_pkg::V_DISP,
  parameter int   V_FP     = vga_timing_pkg::V_FP,
  parameter int   V_SYNC   = vga_timing_pkg::V_SYNC,
  parameter int   V_BP     = vga_timing_pkg::V_BP,
  parameter logic SYNC_POL = vga_timing_pkg::SYNC_POL
) (
  input  logic       clk,
  input  logic       reset,
  vga_sync_if.master vga
);
  import vga_timing_pkg::*;

  localparam int H_TOT = H_DISP + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_DISP + V_FP + V_SYNC + V_BP;

  if ((H_TOT > 1024) || (V_TOT > 1024)) begin : g_bad_total
    $error("vga_sync: H/V totals must fit in 10-bit counters");
  end

  localparam coord_t H_LAST = coord_t'(H_TOT - 1);
  localparam coord_t V_LAST = coord_t'(V_TOT - 1);
  localparam coord_t H_VIS  = coord_t'(H_DISP);
  localparam coord_t V_VIS  = coord_t'(V_DISP);
  localparam coord_t HS_LO  = coord_t'(H_DISP + H_FP);
  localparam coord_t HS_HI  = coord_t'(H_DISP + H_FP + H_SYNC - 1);
  localparam coord_t VS_LO  = coord_t'(V_DISP + V_FP);
  localparam coord_t VS_HI  = coord_t'(V_DISP + V_FP + V_SYNC - 1);

  logic   p_tick;
  coord_t x_q, x_d;
  coord_t y_q, y_d;
  logic   hsync_q, hsync_d;
  logic   vsync_q, vsync_d;

  pixel_tick_div #(
    .CLK_DIV (CLK_DIV)
  ) u_tick_div (
    .clk    (clk),
    .reset  (reset),
    .p_tick (p_tick)
  );

  // Syncs decode the next-state coordinates so they flip on the same edge as xpos/ypos.
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (p_tick) begin
      if (x_q == H_LAST) begin
        x_d = '0;
        y_d = (y_q == V_LAST) ? '0 : y_q + coord_t'(1);
      end else begin
        x_d = x_q + coord_t'(1);
      end
    end
    hsync_d = in_window(x_d, HS_LO, HS_HI) ? SYNC_POL : ~SYNC_POL;
    vsync_d = in_window(y_d, VS_LO, VS_HI) ? SYNC_POL : ~SYNC_POL;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      x_q     <= '0;
      y_q     <= '0;
      hsync_q <= ~SYNC_POL;
      vsync_q <= ~SYNC_POL;
    end else begin
      x_q     <= x_d;
      y_q     <= y_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
    end
  end

  assign vga.p_tick     = p_tick;
  assign vga.xpos       = x_q;
  assign vga.ypos       = y_q;
  assign vga.video_on   = (x_q < H_VIS) && (y_q < V_VIS);
  assign vga.hsync      = hsync_q;
  assign vga.vsync      = vsync_q;
  assign vga.frame_tick = p_tick && (x_q == H_LAST) && (y_q == V_LAST);

endmodule
`default_nettype wire
